ext_bus_bridge_q: RTL and testbench

//  Next-gen host(ARM)-to-SoC bridge: async parallel host bus, 2-FF synced chip-select access detection, 16-bit register file.

---
 rtl/ext_bus_bridge_q.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ext_bus_bridge_q.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ext_bus_bridge_q.sv
// Host-to-SoC bridge: asynchronous host register bus feeding a command FIFO,
// a ready/valid SoC master FSM with response timeout, and a response FIFO.
module ext_bus_bridge_q #(
    parameter int          CS_WIDTH     = 2,
    parameter int          CMD_DEPTH    = 4,
    parameter int          RSP_DEPTH    = 4,
    parameter int          TIMEOUT_CYC  = 1024,
    parameter logic [15:0] SANITY_VALUE = 16'h5AFE
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [CS_WIDTH-1:0] cs_i,
    input  logic [4:0]          addr_i,
    input  logic                read_i,
    input  logic                write_i,
    input  logic [15:0]         host_data_i,
    output logic [15:0]         host_data_o,
    output logic                host_data_oe_o,
    output logic                cpu_rst_o,
    output logic                soc_rst_o,
    output logic                bus_master_o,
    output logic                tran_valid_o,
    input  logic                tran_ready_i,
    output logic [31:0]         tran_addr_o,
    output logic [31:0]         tran_data_o,
    output logic                tran_we_o,
    output logic [1:0]          tran_size_o,
    input  logic                rsp_valid_i,
    input  logic [31:0]         rsp_data_i,
    input  logic                rsp_err_i,
    output logic                irq_o
);

    localparam int CPW = $clog2(CMD_DEPTH);
    localparam int CCW = CPW + 1;
    localparam int RPW = $clog2(RSP_DEPTH);
    localparam int RCW = RPW + 1;
    localparam int TW  = $clog2(TIMEOUT_CYC);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic [3:0] IDX_SANITY   = 4'd0;
    localparam logic [3:0] IDX_ADDR_LO  = 4'd1;
    localparam logic [3:0] IDX_ADDR_HI  = 4'd2;
    localparam logic [3:0] IDX_WDATA_LO = 4'd3;
    localparam logic [3:0] IDX_WDATA_HI = 4'd4;
    localparam logic [3:0] IDX_CONTROL  = 4'd5;
    localparam logic [3:0] IDX_RDATA_LO = 4'd6;
    localparam logic [3:0] IDX_RDATA_HI = 4'd7;
    localparam logic [3:0] IDX_STATUS   = 4'd8;

    logic [2:0]  cs_sync;
    logic        access, host_rd, host_wr;
    logic [3:0]  reg_idx;
    logic        unused_addr_bit;

    logic [15:0] addr_lo, addr_hi, wdata_lo, wdata_hi;
    logic        ctrl_we, ctrl_irq_en;
    logic [1:0]  ctrl_size;
    logic        ovf, timeout;

    logic [1:0]    state;
    logic          discard;
    logic [TW-1:0] timer;

    logic [66:0]    cmd_mem [CMD_DEPTH];
    logic [CPW-1:0] cmd_wptr, cmd_rptr;
    logic [CCW-1:0] cmd_count;
    logic [66:0]    cmd_entry, cmd_head;

    logic [32:0]    rsp_mem [RSP_DEPTH];
    logic [RPW-1:0] rsp_wptr, rsp_rptr;
    logic [RCW-1:0] rsp_count;
    logic [32:0]    rsp_entry, rsp_head;

    logic        wr_ctrl, push_req, clr, cmd_full, cmd_push, ovf_set;
    logic        fsm_start, tmo_hit, fsm_done, rsp_push, rsp_wr, rsp_pop;
    logic        rsp_nonempty, head_err, busy;
    logic [15:0] control_rd, status_rd, rd_mux;

    assign host_data_oe_o  = ~read_i;
    assign reg_idx         = addr_i[4:1];
    assign unused_addr_bit = addr_i[0];

    // Chip-select synchroniser; one access pulse per rising edge of the combined select
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) cs_sync <= 3'b000;
        else          cs_sync <= {cs_sync[1:0], &cs_i};
    end

    assign access  = cs_sync[1] & ~cs_sync[2];
    assign host_rd = access & ~read_i;
    assign host_wr = access & ~write_i;

    assign wr_ctrl      = host_wr && (reg_idx == IDX_CONTROL);
    assign push_req     = wr_ctrl && host_data_i[3];
    assign clr          = wr_ctrl && host_data_i[5];
    assign busy         = (state != ST_IDLE);
    assign rsp_nonempty = (rsp_count != '0);
    assign cmd_head     = cmd_mem[cmd_rptr];
    assign rsp_head     = rsp_mem[rsp_rptr];
    assign head_err     = rsp_nonempty & rsp_head[32];
    assign rsp_pop      = host_rd && (reg_idx == IDX_RDATA_HI) && rsp_nonempty;
    assign cmd_full     = (cmd_count == CCW'(CMD_DEPTH));

    // Nothing is in flight while idle, so the response-credit check reduces to rsp_count
    assign fsm_start = (state == ST_IDLE) && (cmd_count != '0) &&
                       (rsp_count < RCW'(RSP_DEPTH)) && !clr;
    assign cmd_push  = push_req && (!cmd_full || fsm_start);
    assign ovf_set   = push_req && cmd_full && !fsm_start;
    assign cmd_entry = {addr_hi, addr_lo, wdata_hi, wdata_lo, host_data_i[4], host_data_i[8:7]};

    assign tmo_hit   = (timer == TW'(TIMEOUT_CYC - 1));
    assign fsm_done  = (state == ST_WAIT) && (rsp_valid_i || tmo_hit);
    assign rsp_push  = fsm_done && !discard;
    assign rsp_wr    = rsp_push && ((rsp_count != RCW'(RSP_DEPTH)) || rsp_pop);
    assign rsp_entry = rsp_valid_i ? {rsp_err_i, (tran_we_o ? 32'h0 : rsp_data_i)}
                                   : {1'b1, 32'hDEADBEEF};

    assign control_rd = {6'b0, ctrl_irq_en, ctrl_size, rsp_nonempty, 1'b0, ctrl_we,
                         1'b0, bus_master_o, soc_rst_o, cpu_rst_o};
    assign status_rd  = {4'b0, busy, timeout, ovf, head_err, 4'(rsp_count), 4'(cmd_count)};

    always_comb begin
        rd_mux = 16'h0;
        case (reg_idx)
            IDX_SANITY:   rd_mux = SANITY_VALUE;
            IDX_ADDR_LO:  rd_mux = addr_lo;
            IDX_ADDR_HI:  rd_mux = addr_hi;
            IDX_WDATA_LO: rd_mux = wdata_lo;
            IDX_WDATA_HI: rd_mux = wdata_hi;
            IDX_CONTROL:  rd_mux = control_rd;
            IDX_RDATA_LO: rd_mux = rsp_nonempty ? rsp_head[15:0]  : 16'h0;
            IDX_RDATA_HI: rd_mux = rsp_nonempty ? rsp_head[31:16] : 16'h0;
            IDX_STATUS:   rd_mux = status_rd;
            default:      rd_mux = 16'h0;
        endcase
    end

    // Read captures the pre-write value when both strobes are low on the same access
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            host_data_o  <= 16'h0;
            addr_lo      <= 16'h0;
            addr_hi      <= 16'h0;
            wdata_lo     <= 16'h0;
            wdata_hi     <= 16'h0;
            cpu_rst_o    <= 1'b0;
            soc_rst_o    <= 1'b0;
            bus_master_o <= 1'b0;
            ctrl_we      <= 1'b0;
            ctrl_size    <= 2'b00;
            ctrl_irq_en  <= 1'b0;
        end else begin
            if (host_rd) host_data_o <= rd_mux;
            if (host_wr) begin
                case (reg_idx)
                    IDX_ADDR_LO:  addr_lo  <= host_data_i;
                    IDX_ADDR_HI:  addr_hi  <= host_data_i;
                    IDX_WDATA_LO: wdata_lo <= host_data_i;
                    IDX_WDATA_HI: wdata_hi <= host_data_i;
                    IDX_CONTROL: begin
                        cpu_rst_o    <= host_data_i[0];
                        soc_rst_o    <= host_data_i[1];
                        bus_master_o <= host_data_i[2];
                        ctrl_we      <= host_data_i[4];
                        ctrl_size    <= host_data_i[8:7];
                        ctrl_irq_en  <= host_data_i[9];
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
            for (int i = 0; i < CMD_DEPTH; i++) cmd_mem[i] <= '0;
        end else if (clr) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
        end else begin
            if (cmd_push) begin
                cmd_mem[cmd_wptr] <= cmd_entry;
                cmd_wptr          <= cmd_wptr + CPW'(1);
            end
            if (fsm_start) cmd_rptr <= cmd_rptr + CPW'(1);
            case ({cmd_push, fsm_start})
                2'b10:   cmd_count <= cmd_count + CCW'(1);
                2'b01:   cmd_count <= cmd_count - CCW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rsp_wptr  <= '0;
            rsp_rptr  <= '0;
            rsp_count <= '0;
            for (int i = 0; i < RSP_DEPTH; i++) rsp_mem[i] <= '0;
        end else if (clr) begin
            rsp_wptr  <= '0;
            rsp_rptr  <= '0;
            rsp_count <= '0;
        end else begin
            if (rsp_wr) begin
                rsp_mem[rsp_wptr] <= rsp_entry;
                rsp_wptr          <= rsp_wptr + RPW'(1);
            end
            if (rsp_pop) rsp_rptr <= rsp_rptr + RPW'(1);
            case ({rsp_wr, rsp_pop})
                2'b10:   rsp_count <= rsp_count + RCW'(1);
                2'b01:   rsp_count <= rsp_count - RCW'(1);
                default: ;
            endcase
        end
    end

    // A flushed transaction keeps its handshake but never reaches the response FIFO
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state        <= ST_IDLE;
            discard      <= 1'b0;
            timer        <= '0;
            tran_valid_o <= 1'b0;
            tran_addr_o  <= 32'h0;
            tran_data_o  <= 32'h0;
            tran_we_o    <= 1'b0;
            tran_size_o  <= 2'b00;
        end else begin
            if (fsm_done)                     discard <= 1'b0;
            else if (clr && state != ST_IDLE) discard <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (fsm_start) begin
                        tran_addr_o  <= cmd_head[66:35];
                        tran_data_o  <= cmd_head[34:3];
                        tran_we_o    <= cmd_head[2];
                        tran_size_o  <= cmd_head[1:0];
                        tran_valid_o <= 1'b1;
                        state        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tran_ready_i) begin
                        tran_valid_o <= 1'b0;
                        timer        <= '0;
                        state        <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    timer <= timer + TW'(1);
                    if (fsm_done) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ovf     <= 1'b0;
            timeout <= 1'b0;
            irq_o   <= 1'b0;
        end else begin
            if (clr) begin
                ovf     <= 1'b0;
                timeout <= 1'b0;
            end else begin
                if (ovf_set) ovf <= 1'b1;
                if (state == ST_WAIT && tmo_hit && !rsp_valid_i && !discard) timeout <= 1'b1;
            end
            irq_o <= ctrl_irq_en & (rsp_nonempty | ovf | timeout);
        end
    end

endmodule

// File: tb/tb_ext_bus_bridge_q.sv
// Directed bench for ext_bus_bridge_q: host register accesses, SoC handshakes,
// FIFO ordering, overflow, timeout, flush and asynchronous reset.
module tb_ext_bus_bridge_q;

    localparam int TIMEOUT_CYC = 1024;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [1:0]  cs_i;
    logic [4:0]  addr_i;
    logic        read_i, write_i;
    logic [15:0] host_data_i;
    logic [15:0] host_data_o;
    logic        host_data_oe_o;
    logic        cpu_rst_o, soc_rst_o, bus_master_o;
    logic        tran_valid_o, tran_ready_i;
    logic [31:0] tran_addr_o, tran_data_o;
    logic        tran_we_o;
    logic [1:0]  tran_size_o;
    logic        rsp_valid_i;
    logic [31:0] rsp_data_i;
    logic        rsp_err_i;
    logic        irq_o;

    int nVectors = 0;
    int nFail    = 0;
    int beats    = 0;

    ext_bus_bridge_q #(
        .CS_WIDTH(2), .CMD_DEPTH(4), .RSP_DEPTH(4),
        .TIMEOUT_CYC(TIMEOUT_CYC), .SANITY_VALUE(16'h5AFE)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .cs_i(cs_i), .addr_i(addr_i),
        .read_i(read_i), .write_i(write_i), .host_data_i(host_data_i),
        .host_data_o(host_data_o), .host_data_oe_o(host_data_oe_o),
        .cpu_rst_o(cpu_rst_o), .soc_rst_o(soc_rst_o), .bus_master_o(bus_master_o),
        .tran_valid_o(tran_valid_o), .tran_ready_i(tran_ready_i),
        .tran_addr_o(tran_addr_o), .tran_data_o(tran_data_o),
        .tran_we_o(tran_we_o), .tran_size_o(tran_size_o),
        .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_err_i(rsp_err_i),
        .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    // Counts accepted SoC request beats
    always @(posedge clk_i) begin
        if (tran_valid_o && tran_ready_i) beats++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nVectors++;
        assert (observed === expected) else begin
            nFail++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One host bus cycle: select held long enough for the synchroniser, then released
    task automatic applyStimulus(input logic [3:0] idx, input logic [15:0] data,
                                 input bit doRead, input bit doWrite);
        addr_i      = {idx, 1'b0};
        host_data_i = data;
        read_i      = !doRead;
        write_i     = !doWrite;
        @(negedge clk_i);
        cs_i = 2'b11;
        repeat (5) @(negedge clk_i);
        cs_i    = 2'b00;
        read_i  = 1'b1;
        write_i = 1'b1;
        repeat (4) @(negedge clk_i);
    endtask

    task automatic readReg(input logic [3:0] idx, output logic [15:0] data);
        applyStimulus(idx, 16'h0, 1'b1, 1'b0);
        data = host_data_o;
    endtask

    task automatic waitValid();
        for (int i = 0; i < 50 && tran_valid_o !== 1'b1; i++) @(negedge clk_i);
        checkOutput("tran_valid_wait", {31'h0, tran_valid_o}, 32'h1);
    endtask

    task automatic acceptReq();
        waitValid();
        tran_ready_i = 1'b1;
        @(negedge clk_i);
        tran_ready_i = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic err);
        rsp_valid_i = 1'b1;
        rsp_data_i  = data;
        rsp_err_i   = err;
        @(negedge clk_i);
        rsp_valid_i = 1'b0;
        rsp_err_i   = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic socServe(input logic [31:0] data, input logic err);
        acceptReq();
        respond(data, err);
    endtask

    logic [15:0] rd;

    initial begin
        reset_i      = 1'b0;
        cs_i         = 2'b00;
        addr_i       = 5'h0;
        read_i       = 1'b1;
        write_i      = 1'b1;
        host_data_i  = 16'h0;
        tran_ready_i = 1'b0;
        rsp_valid_i  = 1'b0;
        rsp_data_i   = 32'h0;
        rsp_err_i    = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);

        // Reset state
        checkOutput("rst_valid", {31'h0, tran_valid_o}, 32'h0);
        checkOutput("rst_addr", tran_addr_o, 32'h0);
        checkOutput("rst_data", tran_data_o, 32'h0);
        checkOutput("rst_we_size", {29'h0, tran_we_o, tran_size_o}, 32'h0);
        checkOutput("rst_irq", {31'h0, irq_o}, 32'h0);
        checkOutput("rst_hdata", {16'h0, host_data_o}, 32'h0);
        checkOutput("oe_idle", {31'h0, host_data_oe_o}, 32'h0);
        read_i = 1'b0;
        #1;
        checkOutput("oe_read", {31'h0, host_data_oe_o}, 32'h1);
        read_i = 1'b1;

        readReg(4'd0, rd); checkOutput("sanity", {16'h0, rd}, 32'h5AFE);
        readReg(4'd5, rd); checkOutput("control_rst", {16'h0, rd}, 32'h0);
        readReg(4'd8, rd); checkOutput("status_rst", {16'h0, rd}, 32'h0);

        // Simultaneous read and write returns the old value
        applyStimulus(4'd1, 16'h1234, 1'b0, 1'b1);
        applyStimulus(4'd1, 16'hABCD, 1'b1, 1'b1);
        checkOutput("rw_old", {16'h0, host_data_o}, 32'h1234);
        readReg(4'd1, rd); checkOutput("rw_new", {16'h0, rd}, 32'hABCD);

        applyStimulus(4'd10, 16'hFFFF, 1'b0, 1'b1);
        readReg(4'd10, rd); checkOutput("unmapped", {16'h0, rd}, 32'h0);
        applyStimulus(4'd0, 16'h0000, 1'b0, 1'b1);
        readReg(4'd0, rd); checkOutput("sanity_ro", {16'h0, rd}, 32'h5AFE);

        applyStimulus(4'd5, 16'h0007, 1'b0, 1'b1);
        checkOutput("ctrl_outs", {29'h0, bus_master_o, soc_rst_o, cpu_rst_o}, 32'h7);
        readReg(4'd5, rd); checkOutput("ctrl_rd", {16'h0, rd}, 32'h0007);
        applyStimulus(4'd5, 16'h0000, 1'b0, 1'b1);

        // Single write transaction stalled for 3 cycles
        applyStimulus(4'd1, 16'h0040, 1'b0, 1'b1);
        applyStimulus(4'd2, 16'h1000, 1'b0, 1'b1);
        applyStimulus(4'd3, 16'hBABE, 1'b0, 1'b1);
        applyStimulus(4'd4, 16'hCAFE, 1'b0, 1'b1);
        applyStimulus(4'd5, 16'h0118, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checkOutput("stall_valid", {31'h0, tran_valid_o}, 32'h1);
            checkOutput("stall_addr", tran_addr_o, 32'h1000_0040);
            checkOutput("stall_data", tran_data_o, 32'hCAFE_BABE);
            checkOutput("stall_we_size", {29'h0, tran_we_o, tran_size_o}, 32'h6);
        end
        tran_ready_i = 1'b1;
        @(negedge clk_i);
        tran_ready_i = 1'b0;
        checkOutput("valid_drop", {31'h0, tran_valid_o}, 32'h0);
        readReg(4'd5, rd); checkOutput("ctrl_push_clr", {16'h0, rd}, 32'h0110);
        respond(32'hFFFF_FFFF, 1'b0);
        checkOutput("one_beat", beats, 32'd1);
        readReg(4'd8, rd); checkOutput("status_wr", {16'h0, rd}, 32'h0010);
        readReg(4'd5, rd); checkOutput("ctrl_nonempty", {16'h0, rd}, 32'h0150);
        readReg(4'd6, rd); checkOutput("wr_rsp_lo", {16'h0, rd}, 32'h0);
        readReg(4'd7, rd); checkOutput("wr_rsp_hi", {16'h0, rd}, 32'h0);
        readReg(4'd8, rd); checkOutput("status_popped", {16'h0, rd}, 32'h0);

        // Four queued reads return in order
        for (int i = 0; i < 4; i++) applyStimulus(4'd5, 16'h0108, 1'b0, 1'b1);
        socServe(32'h11, 1'b0);
        socServe(32'h22, 1'b0);
        socServe(32'h33, 1'b0);
        socServe(32'h44, 1'b0);
        readReg(4'd8, rd); checkOutput("status_4rsp", {16'h0, rd}, 32'h0040);
        for (int i = 0; i < 4; i++) begin
            readReg(4'd6, rd); checkOutput("order_lo", {16'h0, rd}, 32'h11 * (i + 1));
            readReg(4'd7, rd); checkOutput("order_hi", {16'h0, rd}, 32'h0);
        end
        readReg(4'd7, rd); checkOutput("empty_hi", {16'h0, rd}, 32'h0);
        readReg(4'd6, rd); checkOutput("empty_lo", {16'h0, rd}, 32'h0);
        readReg(4'd8, rd); checkOutput("status_empty", {16'h0, rd}, 32'h0);

        // Error response reaches STATUS head err
        applyStimulus(4'd5, 16'h0108, 1'b0, 1'b1);
        socServe(32'hA5A5_0001, 1'b1);
        readReg(4'd8, rd); checkOutput("status_err", {16'h0, rd}, 32'h0110);
        readReg(4'd6, rd); checkOutput("err_lo", {16'h0, rd}, 32'h0001);
        readReg(4'd7, rd); checkOutput("err_hi", {16'h0, rd}, 32'hA5A5);

        // Overflow: one in REQ, four queued, sixth dropped
        for (int i = 0; i < 6; i++) applyStimulus(4'd5, 16'h0108, 1'b0, 1'b1);
        readReg(4'd8, rd); checkOutput("status_ovf", {16'h0, rd}, 32'h0A04);
        applyStimulus(4'd5, 16'h0020, 1'b0, 1'b1);
        readReg(4'd8, rd); checkOutput("status_clr_req", {16'h0, rd}, 32'h0800);
        socServe(32'h55, 1'b0);
        readReg(4'd8, rd); checkOutput("status_discard", {16'h0, rd}, 32'h0);

        // Timeout with interrupt enabled, then a late response
        applyStimulus(4'd5, 16'h0308, 1'b0, 1'b1);
        acceptReq();
        repeat (TIMEOUT_CYC + 5) @(negedge clk_i);
        checkOutput("irq_tmo", {31'h0, irq_o}, 32'h1);
        readReg(4'd8, rd); checkOutput("status_tmo", {16'h0, rd}, 32'h0510);
        readReg(4'd6, rd); checkOutput("tmo_lo", {16'h0, rd}, 32'hBEEF);
        readReg(4'd7, rd); checkOutput("tmo_hi", {16'h0, rd}, 32'hDEAD);
        respond(32'h99, 1'b0);
        readReg(4'd8, rd); checkOutput("status_late", {16'h0, rd}, 32'h0400);
        checkOutput("irq_sticky", {31'h0, irq_o}, 32'h1);
        applyStimulus(4'd5, 16'h0220, 1'b0, 1'b1);
        readReg(4'd8, rd); checkOutput("status_clr_tmo", {16'h0, rd}, 32'h0);
        checkOutput("irq_cleared", {31'h0, irq_o}, 32'h0);

        // Flush during WAIT discards the in-flight response
        applyStimulus(4'd5, 16'h0108, 1'b0, 1'b1);
        acceptReq();
        readReg(4'd8, rd); checkOutput("status_wait", {16'h0, rd}, 32'h0800);
        applyStimulus(4'd5, 16'h0020, 1'b0, 1'b1);
        respond(32'h77, 1'b0);
        readReg(4'd8, rd); checkOutput("status_flushed", {16'h0, rd}, 32'h0);
        applyStimulus(4'd5, 16'h0108, 1'b0, 1'b1);
        socServe(32'h1234_5678, 1'b0);
        readReg(4'd8, rd); checkOutput("status_after", {16'h0, rd}, 32'h0010);
        readReg(4'd6, rd); checkOutput("after_lo", {16'h0, rd}, 32'h5678);
        readReg(4'd7, rd); checkOutput("after_hi", {16'h0, rd}, 32'h1234);

        // Asynchronous reset while a request is pending
        applyStimulus(4'd5, 16'h0108, 1'b0, 1'b1);
        waitValid();
        reset_i = 1'b0;
        #1;
        checkOutput("arst_valid", {31'h0, tran_valid_o}, 32'h0);
        checkOutput("arst_addr", tran_addr_o, 32'h0);
        @(negedge clk_i);
        reset_i = 1'b1;
        readReg(4'd8, rd); checkOutput("arst_status", {16'h0, rd}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
        $finish;
    end

endmodule
